// File: rtl/cmul_operand_loader.sv
// -----------------------------------------------------------------------------
// cmul_operand_loader
//
// Hardware driver for the complex triple-product multiplier. Six signed Q3.2
// operand words arrive one at a time on a valid/ready stream. They are placed
// in the areal, aimag, breal, bimag, creal, cimag slots in that order and then
// presented in parallel. The loader then pulses input_rdy for one cycle and
// waits LATENCY cycles. It captures preal/pimag (Q10.5) and offers the pair on
// a valid/ready result port.
//
// Build option:
//   CMUL_LOADER_PREFETCH_EN - adds a shadow operand bank. The bank keeps
//     accepting the next set while the current set is in flight. On the result
//     handshake a full shadow set is fired straight away. A partial shadow set
//     is moved into the active slots, and loading resumes from that count.
//
// Ports:
//   clk                      rising-edge clock
//   reset                    asynchronous, active-low reset
//   s_valid/s_ready/s_data   serial operand stream (signed IW bits)
//   areal..cimag             parallel operands to the multiplier
//   input_rdy                one-cycle start pulse to the multiplier
//   preal/pimag              multiplier result (signed OW bits)
//   r_valid/r_ready          result handshake
//   r_real/r_imag            captured result
//   busy                     low only when idle in LOAD with no words held
// -----------------------------------------------------------------------------
module cmul_operand_loader #(
    parameter int IW      = 5,
    parameter int OW      = 15,
    parameter int LATENCY = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [IW-1:0] s_data,
    output logic signed [IW-1:0] areal,
    output logic signed [IW-1:0] aimag,
    output logic signed [IW-1:0] breal,
    output logic signed [IW-1:0] bimag,
    output logic signed [IW-1:0] creal,
    output logic signed [IW-1:0] cimag,
    output logic                 input_rdy,
    input  logic signed [OW-1:0] preal,
    input  logic signed [OW-1:0] pimag,
    output logic                 r_valid,
    input  logic                 r_ready,
    output logic signed [OW-1:0] r_real,
    output logic signed [OW-1:0] r_imag,
    output logic                 busy
);

    localparam int         NSLOT     = 6;
    localparam logic [2:0] LAST_SLOT = 3'd5;
    localparam logic [2:0] FULL_CNT  = 3'd6;
    localparam logic [7:0] LAT_LOAD  = 8'(LATENCY);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [7:0]           lat_q, lat_d;
    logic signed [IW-1:0] op_q [NSLOT];
    logic signed [IW-1:0] op_d [NSLOT];
    logic                 input_rdy_q, input_rdy_d;
    logic                 r_valid_q, r_valid_d;
    logic signed [OW-1:0] r_real_q, r_real_d;
    logic signed [OW-1:0] r_imag_q, r_imag_d;
    logic                 accept;

`ifdef CMUL_LOADER_PREFETCH_EN
    logic signed [IW-1:0] sh_q [NSLOT];
    logic signed [IW-1:0] sh_d [NSLOT];
    logic [2:0]           sh_cnt_q, sh_cnt_d;

    // Outside LOAD the stream feeds the shadow bank until it is full.
    assign s_ready = (state_q == LOAD) || (sh_cnt_q != FULL_CNT);
`else
    assign s_ready = (state_q == LOAD);
`endif

    assign accept = s_valid && s_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        op_d        = op_q;
        input_rdy_d = 1'b0;
        r_valid_d   = r_valid_q;
        r_real_d    = r_real_q;
        r_imag_d    = r_imag_q;
`ifdef CMUL_LOADER_PREFETCH_EN
        sh_d     = sh_q;
        sh_cnt_d = sh_cnt_q;
        if (accept && (state_q != LOAD)) begin
            for (int i = 0; i < NSLOT; i++) begin
                if (sh_cnt_q == 3'(i)) sh_d[i] = s_data;
            end
            sh_cnt_d = sh_cnt_q + 3'd1;
        end
`endif

        unique case (state_q)
            LOAD: begin
                if (accept) begin
                    for (int i = 0; i < NSLOT; i++) begin
                        if (cnt_q == 3'(i)) op_d[i] = s_data;
                    end
                    if (cnt_q == LAST_SLOT) begin
                        cnt_d       = 3'd0;
                        state_d     = FIRE;
                        input_rdy_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            FIRE: begin
                state_d = WAIT;
                lat_d   = LAT_LOAD;
            end
            WAIT: begin
                lat_d = lat_q - 8'd1;
                // The counter hits zero on this edge, so the result is valid now.
                if (lat_q == 8'd1) begin
                    r_real_d  = preal;
                    r_imag_d  = pimag;
                    r_valid_d = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                // r_valid is always high in HOLD, so r_ready alone completes the handshake.
                if (r_ready) begin
                    r_valid_d = 1'b0;
                    state_d   = LOAD;
`ifdef CMUL_LOADER_PREFETCH_EN
                    // sh_*_d already include a word accepted on this same edge.
                    if (sh_cnt_d == FULL_CNT) begin
                        op_d        = sh_d;
                        state_d     = FIRE;
                        input_rdy_d = 1'b1;
                    end else begin
                        for (int i = 0; i < NSLOT; i++) begin
                            if (3'(i) < sh_cnt_d) op_d[i] = sh_d[i];
                        end
                        cnt_d = sh_cnt_d;
                    end
                    sh_cnt_d = 3'd0;
`endif
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= LOAD;
            cnt_q       <= 3'd0;
            lat_q       <= 8'd0;
            input_rdy_q <= 1'b0;
            r_valid_q   <= 1'b0;
            r_real_q    <= '0;
            r_imag_q    <= '0;
            for (int i = 0; i < NSLOT; i++) op_q[i] <= '0;
`ifdef CMUL_LOADER_PREFETCH_EN
            sh_cnt_q <= 3'd0;
            for (int i = 0; i < NSLOT; i++) sh_q[i] <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_q       <= lat_d;
            input_rdy_q <= input_rdy_d;
            r_valid_q   <= r_valid_d;
            r_real_q    <= r_real_d;
            r_imag_q    <= r_imag_d;
            op_q        <= op_d;
`ifdef CMUL_LOADER_PREFETCH_EN
            sh_cnt_q <= sh_cnt_d;
            sh_q     <= sh_d;
`endif
        end
    end

    assign areal     = op_q[0];
    assign aimag     = op_q[1];
    assign breal     = op_q[2];
    assign bimag     = op_q[3];
    assign creal     = op_q[4];
    assign cimag     = op_q[5];
    assign input_rdy = input_rdy_q;
    assign r_valid   = r_valid_q;
    assign r_real    = r_real_q;
    assign r_imag    = r_imag_q;
    assign busy      = !((state_q == LOAD) && (cnt_q == 3'd0));

endmodule

// File: tb/tb_cmul_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_cmul_operand_loader
//
// Bench for cmul_operand_loader. A transaction-level reference model tracks the
// accepted words as a queue and the set in flight as a flag plus an age. Each
// cycle it predicts s_ready, input_rdy, r_valid, busy and the operand bus. A
// fired set pushes its expected triple product onto a scoreboard queue. A
// separate monitor compares each presented result against that queue. A small
// multiplier model drives the correct product only in the cycle before the
// capture edge. It drives random values at all other times.
// -----------------------------------------------------------------------------
module tb_cmul_operand_loader;

    localparam int IW  = 5;
    localparam int OW  = 15;
    localparam int LAT = 10;
`ifdef CMUL_LOADER_PREFETCH_EN
    localparam bit PREF = 1'b1;
`else
    localparam bit PREF = 1'b0;
`endif

    logic                 clk     = 1'b0;
    logic                 reset   = 1'b1;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic signed [IW-1:0] s_data  = '0;
    logic signed [IW-1:0] areal, aimag, breal, bimag, creal, cimag;
    logic                 input_rdy;
    logic signed [OW-1:0] preal   = '0;
    logic signed [OW-1:0] pimag   = '0;
    logic                 r_valid;
    logic                 r_ready = 1'b0;
    logic signed [OW-1:0] r_real, r_imag;
    logic                 busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    logic signed [IW-1:0] acc [$];
    logic signed [IW-1:0] cur_set [6];
    logic signed [OW-1:0] sbq_re [$];
    logic signed [OW-1:0] sbq_im [$];
    bit                   in_flight = 1'b0;
    int                   age       = 0;
    bit                   acc_flag  = 1'b0;
    int                   rr_mode   = 0;

    cmul_operand_loader #(.IW(IW), .OW(OW), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .areal(areal), .aimag(aimag), .breal(breal), .bimag(bimag),
        .creal(creal), .cimag(cimag),
        .input_rdy(input_rdy), .preal(preal), .pimag(pimag),
        .r_valid(r_valid), .r_ready(r_ready),
        .r_real(r_real), .r_imag(r_imag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // (a*b*c) from Q3.2 operands: the full product has 6 fraction bits, and the
    // Q10.5 result drops one of them.
    function automatic void triple(input int ar, input int ai, input int br, input int bi,
                                   input int cr, input int ci,
                                   output logic signed [OW-1:0] pr,
                                   output logic signed [OW-1:0] pi);
        int abr, abi, tr, ti;
        abr = ar * br - ai * bi;
        abi = ar * bi + ai * br;
        tr  = abr * cr - abi * ci;
        ti  = abr * ci + abi * cr;
        pr  = OW'(tr >>> 1);
        pi  = OW'(ti >>> 1);
    endfunction

    // reference model: checks outputs seen after the last edge, then predicts the next edge
    initial begin
        bit m_ready, exp_rv, hs;
        logic signed [OW-1:0] er, ei;
        forever begin
            @(negedge clk);
            if (!reset) begin
                acc.delete();
                sbq_re.delete();
                sbq_im.delete();
                in_flight = 1'b0;
                age       = 0;
                acc_flag  = 1'b0;
            end else begin
                m_ready = (acc.size() < 6) && (PREF || !in_flight);
                exp_rv  = in_flight && (age >= LAT + 1);
                chk("s_ready", s_ready, m_ready);
                chk("input_rdy", input_rdy, in_flight && (age == 0));
                chk("r_valid", r_valid, exp_rv);
                chk("busy", busy, in_flight || (acc.size() != 0));
                if (in_flight)
                    chk("operands", {areal, aimag, breal, bimag, creal, cimag},
                        {cur_set[0], cur_set[1], cur_set[2], cur_set[3], cur_set[4], cur_set[5]});
                acc_flag = s_valid && m_ready;
                if (acc_flag) acc.push_back(s_data);
                hs = exp_rv && r_ready;
                if (in_flight) begin
                    age++;
                    if (hs) in_flight = 1'b0;
                end
                if (!in_flight && acc.size() >= 6) begin
                    for (int i = 0; i < 6; i++) cur_set[i] = acc.pop_front();
                    triple(cur_set[0], cur_set[1], cur_set[2], cur_set[3], cur_set[4], cur_set[5], er, ei);
                    sbq_re.push_back(er);
                    sbq_im.push_back(ei);
                    in_flight = 1'b1;
                    age       = 0;
                end
            end
        end
    end

    // monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (reset && r_valid) begin
                if (sbq_re.size() == 0) begin
                    chk("r_valid_unexpected", r_valid, 1'b0);
                end else begin
                    chk("r_real", r_real, sbq_re[0]);
                    chk("r_imag", r_imag, sbq_im[0]);
                    if (r_ready) begin
                        void'(sbq_re.pop_front());
                        void'(sbq_im.pop_front());
                    end
                end
            end
        end
    end

    // multiplier model: the product is valid only in the cycle before the capture edge
    initial begin
        int mcnt;
        logic signed [IW-1:0] m_ops [6];
        logic signed [OW-1:0] pr, pi;
        mcnt = -1;
        forever begin
            @(negedge clk);
            if (!reset) begin
                mcnt = -1;
            end else if (input_rdy) begin
                mcnt = 0;
                m_ops[0] = areal; m_ops[1] = aimag; m_ops[2] = breal;
                m_ops[3] = bimag; m_ops[4] = creal; m_ops[5] = cimag;
            end else if (mcnt >= 0 && mcnt < 100000) begin
                mcnt++;
            end
            if (mcnt == LAT) begin
                triple(m_ops[0], m_ops[1], m_ops[2], m_ops[3], m_ops[4], m_ops[5], pr, pi);
                preal = pr;
                pimag = pi;
            end else begin
                preal = OW'($urandom);
                pimag = OW'($urandom);
            end
        end
    end

    // result consumer: 0 = always ready, 1 = random, 2 = stalled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       r_ready = 1'b1;
                1:       r_ready = ($urandom_range(0, 2) != 0);
                default: r_ready = 1'b0;
            endcase
        end
    end

    // All stimulus tasks start and end at 1 time unit after a rising edge.
    task automatic send_word(input logic signed [IW-1:0] w);
        int tries;
        tries   = 0;
        s_valid = 1'b1;
        s_data  = w;
        do begin
            @(posedge clk);
            #1;
            tries++;
        end while (!acc_flag && tries < 300);
        if (!acc_flag) chk("send_timeout", acc_flag, 1'b1);
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n, input bit junk);
        repeat (n) begin
            s_valid = junk ? ($urandom_range(0, 1) == 1) : 1'b0;
            s_data  = IW'($urandom);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_rvalid(input int maxc);
        int c;
        c = 0;
        while (!r_valid && c < maxc) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (!r_valid) chk("rvalid_timeout", r_valid, 1'b1);
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("rst_operands", {areal, aimag, breal, bimag, creal, cimag}, 30'd0);
        chk("rst_r_real", r_real, 0);
        chk("rst_r_imag", r_imag, 0);
        chk("rst_input_rdy", input_rdy, 1'b0);
        chk("rst_r_valid", r_valid, 1'b0);
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #1;
        do_reset();

        // (3+2j)(3-2j)(3+2j) = 39+26j
        rr_mode = 0;
        send_word(5'sd12); send_word(5'sd8);  send_word(5'sd12);
        send_word(-5'sd8); send_word(5'sd12); send_word(5'sd8);
        wait_rvalid(40);
        chk("dir_real", r_real, 1248);
        chk("dir_imag", r_imag, 832);
        idle(3, 1'b0);

        // gapped input, result held back for 5 cycles while junk is offered
        rr_mode = 2;
        for (int i = 0; i < 6; i++) begin
            idle(2, 1'b0);
            send_word(IW'($urandom));
        end
        wait_rvalid(60);
        idle(5, 1'b1);
        rr_mode = 0;
        idle(4, 1'b0);

        // most negative code in every slot: (-4-4j)^3 = 128-128j
        for (int i = 0; i < 6; i++) send_word(-5'sd16);
        wait_rvalid(40);
        chk("neg16_operands", {areal, aimag, breal, bimag, creal, cimag}, {6{5'b10000}});
        chk("neg16_real", r_real, 4096);
        chk("neg16_imag", r_imag, -4096);
        idle(3, 1'b0);

        // reset during WAIT, then again with a partly loaded set
        for (int i = 0; i < 6; i++) send_word(IW'($urandom));
        idle(4, 1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) send_word(IW'($urandom));
        do_reset();
        for (int i = 0; i < 6; i++) send_word(IW'($urandom));
        wait_rvalid(40);
        idle(3, 1'b0);

`ifdef CMUL_LOADER_PREFETCH_EN
        // twelve words back to back fill the active and shadow banks
        rr_mode = 0;
        for (int i = 0; i < 12; i++) send_word(IW'($urandom));
        idle(40, 1'b0);
`endif

        // randomized traffic with consumer stalls and one reset
        for (int k = 0; k < 1500; k++) begin
            if (k % 100 == 0) rr_mode = $urandom_range(0, 2);
            if (k == 777) do_reset();
            idle(1, 1'b1);
        end

        // drain
        rr_mode = 0;
        begin
            int c;
            c = 0;
            while (in_flight && c < 200) begin
                idle(1, 1'b0);
                c++;
            end
            if (in_flight) chk("drain_timeout", in_flight, 1'b0);
        end
        idle(2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
